// File: rtl/mc_sequencer.sv
// Multi-cycle RV32 control sequencer: state machine, datapath strobes, memory/muldiv
// wait supervision with timeout trap, sticky fault flags and retired-instruction counter.
module mc_sequencer #(
    parameter int XLEN      = 32,
    parameter int CNT_W     = 32,
    parameter int WAIT_MAX  = 16,
    parameter int EN_MULDIV = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             funct7b0,
    input  logic             zero,
    input  logic             lt,
    input  logic             ltu,
    input  logic             mem_ready,
    input  logic             md_done,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             md_start,
    output logic [1:0]       alu_srcA,
    output logic [1:0]       alu_srcB,
    output logic [1:0]       result_src,
    output logic [2:0]       imm_src,
    output logic [3:0]       alu_control,
    output logic [3:0]       state,
    output logic             illegal,
    output logic             timeout_err,
    output logic [CNT_W-1:0] instret
);
    localparam int WW = $clog2(WAIT_MAX + 1);

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                           ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7,
                           ALU_SRA = 4'd8, ALU_SLTU = 4'd9;

    typedef enum logic [3:0] {
        S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
        S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
        S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_MULDIV = 4'd11,
        S_LUI = 4'd12, S_TRAP = 4'd15
    } state_t;

    if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
        $error("mc_sequencer: XLEN must be 32 or 64");
    end
    if (WAIT_MAX < 1) begin : g_wait_chk
        $error("mc_sequencer: WAIT_MAX must be at least 1");
    end

    state_t           r_state;
    state_t           w_next;
    logic [WW-1:0]    r_wait;
    logic [CNT_W-1:0] r_instret;
    logic             r_illegal;
    logic             r_timeout;
    logic             w_wait_st;
    logic             w_ready;
    logic             w_wait_last;
    logic             w_taken;
    logic [3:0]       w_alu_fn;

    assign w_wait_st   = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                         (r_state == S_MEMWRITE) || (r_state == S_MULDIV);
    assign w_ready     = (r_state == S_MULDIV) ? md_done : mem_ready;
    assign w_wait_last = (r_wait == WW'(WAIT_MAX - 1));

    always_comb begin
        w_alu_fn = ALU_ADD;
        case (funct3)
            3'b000: w_alu_fn = (r_state == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001: w_alu_fn = ALU_SLL;
            3'b010: w_alu_fn = ALU_SLT;
            3'b011: w_alu_fn = ALU_SLTU;
            3'b100: w_alu_fn = ALU_XOR;
            3'b101: w_alu_fn = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110: w_alu_fn = ALU_OR;
            default: w_alu_fn = ALU_AND;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (funct3)
            3'b000: w_taken = zero;
            3'b001: w_taken = !zero;
            3'b100: w_taken = lt;
            3'b101: w_taken = !lt;
            3'b110: w_taken = ltu;
            3'b111: w_taken = !ltu;
            default: w_taken = 1'b0;
        endcase
    end

    // Ready has priority over the last wait cycle, so a late handshake still completes.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (w_ready) w_next = S_DECODE;  else if (w_wait_last) w_next = S_TRAP;
            S_MEMREAD:  if (w_ready) w_next = S_MEMWB;   else if (w_wait_last) w_next = S_TRAP;
            S_MEMWRITE: if (w_ready) w_next = S_FETCH;   else if (w_wait_last) w_next = S_TRAP;
            S_MULDIV:   if (w_ready) w_next = S_ALUWB;   else if (w_wait_last) w_next = S_TRAP;
            S_DECODE: begin
                case (op)
                    7'b0000011, 7'b0100011: w_next = S_MEMADR;
                    7'b0110011: w_next = !funct7b0 ? S_EXECR :
                                         (EN_MULDIV != 0) ? S_MULDIV : S_TRAP;
                    7'b0010011: w_next = S_EXECI;
                    7'b1100011: w_next = S_BRANCH;
                    7'b1101111: w_next = S_JAL;
                    7'b0110111: w_next = S_LUI;
                    default:    w_next = S_TRAP;
                endcase
            end
            S_MEMADR:                 w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_EXECR, S_EXECI, S_JAL:  w_next = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_LUI: w_next = S_FETCH;
            S_TRAP:                   w_next = S_TRAP;
            default:                  w_next = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_instret <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wait  <= (w_wait_st && !w_ready && w_next == r_state) ? r_wait + WW'(1) : '0;
            if (w_next == S_FETCH && r_state != S_FETCH)
                r_instret <= r_instret + CNT_W'(1);
            if (w_next == S_TRAP && r_state == S_DECODE)
                r_illegal <= 1'b1;
            if (w_next == S_TRAP && w_wait_st)
                r_timeout <= 1'b1;
        end
    end

    always_comb begin
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        md_start    = 1'b0;
        alu_srcA    = 2'b00;
        alu_srcB    = 2'b00;
        result_src  = 2'b00;
        imm_src     = 3'b000;
        alu_control = ALU_ADD;
        if (reset_n) begin
            case (r_state)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_srcB   = 2'b10;
                    result_src = 2'b10;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                S_DECODE: begin
                    alu_srcA = 2'b01;
                    alu_srcB = 2'b01;
                    imm_src  = 3'b010;
                end
                S_MEMADR: begin
                    alu_srcA = 2'b10;
                    alu_srcB = 2'b01;
                    imm_src  = op[5] ? 3'b001 : 3'b000;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req   = 1'b1;
                    adr_src   = 1'b1;
                    mem_write = 1'b1;
                end
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                end
                S_EXECR: begin
                    alu_srcA    = 2'b10;
                    alu_control = w_alu_fn;
                end
                S_EXECI: begin
                    alu_srcA    = 2'b10;
                    alu_srcB    = 2'b01;
                    alu_control = w_alu_fn;
                end
                S_ALUWB: reg_write = 1'b1;
                S_BRANCH: begin
                    alu_srcA    = 2'b10;
                    alu_control = ALU_SUB;
                    pc_write    = w_taken;
                end
                S_JAL: begin
                    alu_srcA = 2'b01;
                    alu_srcB = 2'b10;
                    pc_write = 1'b1;
                end
                S_MULDIV: md_start = (r_wait == '0);
                S_LUI: begin
                    alu_srcA   = 2'b10;
                    imm_src    = 3'b100;
                    result_src = 2'b10;
                    reg_write  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state       = r_state;
    assign illegal     = r_illegal;
    assign timeout_err = r_timeout;
    assign instret     = r_instret;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: instruction flows, wait/timeout boundaries,
// fault flags, reset behaviour and instret wrap with a 4-bit counter.
module tb_mc_sequencer;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, funct7b0, zero, lt, ltu, mem_ready, md_done;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, md_start;
    logic [1:0] alu_srcA, alu_srcB, result_src;
    logic [2:0] imm_src;
    logic [3:0] alu_control, state;
    logic       illegal, timeout_err;
    logic [3:0] instret;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] exp_ret  = 4'd0;

    always #5 clk = ~clk;

    mc_sequencer #(.XLEN(32), .CNT_W(4), .WAIT_MAX(16), .EN_MULDIV(1)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .funct7b0(funct7b0), .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .md_done(md_done), .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .md_start(md_start),
        .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .result_src(result_src), .imm_src(imm_src),
        .alu_control(alu_control), .state(state), .illegal(illegal),
        .timeout_err(timeout_err), .instret(instret)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input logic [6:0] o, input logic [2:0] f3,
                                input logic b5, input logic b0);
        op = o; funct3 = f3; funct7b5 = b5; funct7b0 = b0; mem_ready = 1'b1;
        #1;
        check_eq("fetch_state", state, 0);
        check_eq("fetch_ir_write", ir_write, 1);
        tick();
        check_eq("decode_state", state, 1);
        tick();
    endtask

    task automatic retire();
        exp_ret = exp_ret + 4'd1;
        check_eq("retire_state", state, 0);
        check_eq("retire_instret", instret, exp_ret);
    endtask

    task automatic run_alu(input logic [6:0] o, input logic [2:0] f3, input logic b5,
                           input logic [3:0] exp_ctrl, input logic [3:0] exp_state);
        fetch_decode(o, f3, b5, 1'b0);
        check_eq("exec_state", state, exp_state);
        check_eq("exec_alu_control", alu_control, exp_ctrl);
        tick();
        check_eq("aluwb_state", state, 8);
        check_eq("aluwb_reg_write", reg_write, 1);
        tick();
        retire();
    endtask

    task automatic run_branch(input logic [2:0] f3, input logic z, input logic l,
                              input logic lu, input logic exp_pcw);
        zero = z; lt = l; ltu = lu;
        fetch_decode(7'b1100011, f3, 1'b0, 1'b0);
        check_eq("branch_state", state, 9);
        check_eq("branch_alu_sub", alu_control, 1);
        check_eq("branch_pc_write", pc_write, exp_pcw);
        tick();
        retire();
        zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    endtask

    task automatic run_load(input int unsigned low_cycles);
        fetch_decode(7'b0000011, 3'b010, 1'b0, 1'b0);
        check_eq("memadr_state", state, 2);
        check_eq("memadr_imm_I", imm_src, 0);
        mem_ready = 1'b0;
        tick();
        for (int unsigned i = 0; i < low_cycles; i++) begin
            check_eq("memread_wait_state", state, 3);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check_eq("memread_last_state", state, 3);
        check_eq("memread_adr_src", adr_src, 1);
        check_eq("memread_mem_write", mem_write, 0);
        tick();
        check_eq("memwb_state", state, 4);
        check_eq("memwb_reg_write", reg_write, 1);
        check_eq("memwb_result_src", result_src, 1);
        check_eq("memwb_no_timeout", timeout_err, 0);
        tick();
        retire();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0; funct7b0 = 1'b0;
        zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b1; md_done = 1'b0;
        #12;
        check_eq("rst_state", state, 0);
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_instret", instret, 0);
        check_eq("rst_illegal", illegal, 0);
        check_eq("rst_timeout", timeout_err, 0);
        reset_n = 1'b1;
        #1;
        check_eq("first_fetch_mem_req", mem_req, 1);
        check_eq("first_fetch_srcB", alu_srcB, 2);
        check_eq("first_fetch_result_src", result_src, 2);

        run_alu(7'b0110011, 3'b000, 1'b0, 4'd0, 4'd6);  // add
        run_alu(7'b0110011, 3'b000, 1'b1, 4'd1, 4'd6);  // sub
        run_alu(7'b0110011, 3'b011, 1'b0, 4'd9, 4'd6);  // sltu
        run_alu(7'b0010011, 3'b101, 1'b1, 4'd8, 4'd7);  // srai
        run_alu(7'b0010011, 3'b000, 1'b1, 4'd0, 4'd7);  // addi, funct7b5 ignored

        run_load(3);

        fetch_decode(7'b0100011, 3'b010, 1'b0, 1'b0);
        check_eq("sw_memadr_imm_S", imm_src, 1);
        tick();
        check_eq("sw_state", state, 5);
        check_eq("sw_mem_write", mem_write, 1);
        check_eq("sw_mem_req", mem_req, 1);
        tick();
        retire();

        run_branch(3'b000, 1'b1, 1'b0, 1'b0, 1'b1);  // beq taken
        run_branch(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);  // beq not taken
        run_branch(3'b110, 1'b0, 1'b0, 1'b1, 1'b1);  // bltu taken
        run_branch(3'b101, 1'b0, 1'b1, 1'b0, 1'b0);  // bge not taken

        fetch_decode(7'b1101111, 3'b000, 1'b0, 1'b0);
        check_eq("jal_state", state, 10);
        check_eq("jal_pc_write", pc_write, 1);
        check_eq("jal_srcA", alu_srcA, 1);
        tick();
        check_eq("jal_aluwb_state", state, 8);
        tick();
        retire();

        fetch_decode(7'b0110111, 3'b000, 1'b0, 1'b0);
        check_eq("lui_state", state, 12);
        check_eq("lui_imm_src", imm_src, 4);
        check_eq("lui_result_src", result_src, 2);
        check_eq("lui_reg_write", reg_write, 1);
        tick();
        retire();

        md_done = 1'b0;
        fetch_decode(7'b0110011, 3'b000, 1'b0, 1'b1);
        check_eq("md_state", state, 11);
        check_eq("md_start_first", md_start, 1);
        tick();
        check_eq("md_hold_state", state, 11);
        check_eq("md_start_second", md_start, 0);
        md_done = 1'b1;
        tick();
        md_done = 1'b0;
        check_eq("md_aluwb_state", state, 8);
        tick();
        retire();

        run_load(15);  // ready on the cycle the counter would reach WAIT_MAX
        check_eq("instret_full", instret, 15);
        run_alu(7'b0110011, 3'b000, 1'b0, 4'd0, 4'd6);
        check_eq("instret_wrap", instret, 0);

        mem_ready = 1'b0;
        #1;
        for (int unsigned i = 0; i < 16; i++) begin
            check_eq("timeout_wait_state", state, 0);
            check_eq("timeout_ir_write", ir_write, 0);
            tick();
        end
        check_eq("timeout_state", state, 15);
        check_eq("timeout_err", timeout_err, 1);
        check_eq("timeout_mem_req", mem_req, 0);
        check_eq("timeout_illegal", illegal, 0);
        mem_ready = 1'b1;
        tick();
        check_eq("trap_hold_state", state, 15);
        check_eq("trap_hold_ir_write", ir_write, 0);

        reset_n = 1'b0;
        #1;
        check_eq("rst2_state", state, 0);
        check_eq("rst2_timeout", timeout_err, 0);
        check_eq("rst2_instret", instret, 0);
        #2;
        reset_n = 1'b1;
        exp_ret = 4'd0;

        fetch_decode(7'b0000000, 3'b000, 1'b0, 1'b0);
        check_eq("illegal_state", state, 15);
        check_eq("illegal_flag", illegal, 1);
        check_eq("illegal_reg_write", reg_write, 0);
        check_eq("illegal_instret", instret, 0);
        tick();
        check_eq("illegal_sticky", illegal, 1);

        reset_n = 1'b0;
        #1;
        check_eq("rst3_state", state, 0);
        check_eq("rst3_illegal", illegal, 0);
        check_eq("rst3_instret", instret, 0);
        #2;
        reset_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, datapath width (informational; sets no port widths here); CNT_W, default 32, retired-instruction counter width; WAIT_MAX, default 16, maximum memory wait cycles; EN_MULDIV, default 1, enables the RV32M multi-cycle path.
REQ-002 clk  input  1  rising-edge clock; the block has one clock.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 op / funct3 / funct7b5 / funct7b0  input  7/3/1/1  fields of the latched instruction.
REQ-005 zero / lt / ltu  input  1 each  ALU flags: equal, signed less-than, unsigned less-than.
REQ-006 mem_ready  input  1  memory accepts the current access this cycle; md_done  input  1  mul/div result valid.
REQ-007 mem_req / mem_write / adr_src / ir_write / pc_write / reg_write / md_start  output  1 each  datapath strobes.
REQ-008 alu_srcA / alu_srcB / result_src  output  2 each  mux selects; imm_src  output  3; alu_control  output  4.
REQ-009 state  output  4  current state; illegal / timeout_err  output  1 each  sticky faults; instret  output  CNT_W  retired count.

Function
REQ-010 Mux encodings SHALL be: alu_srcA 00=pc, 01=old_pc, 10=A register; alu_srcB 00=B register, 01=imm, 10=constant 4; result_src 00=alu_out, 01=data, 10=alu_res; adr_src 0=pc, 1=result.
REQ-011 imm_src SHALL be 000 I, 001 S, 010 B, 011 J, 100 U; alu_control SHALL be 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sra, 1001 sltu.
REQ-012 States SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, MULDIV=11, LUI=12, TRAP=15.
REQ-013 FETCH SHALL drive mem_req=1, adr_src=0, alu_srcA=00, alu_srcB=10, alu_control=add, result_src=10; ir_write and pc_write SHALL pulse only in the cycle mem_ready=1, then go to DECODE.
REQ-014 DECODE SHALL drive alu_srcA=01, alu_srcB=01, imm_src=010, alu_control=add, then dispatch on op: 0000011/0100011->MEMADR, 0110011->EXECR (MULDIV if funct7b0=1 and EN_MULDIV=1), 0010011->EXECI, 1100011->BRANCH, 1101111->JAL, 0110111->LUI, any other->TRAP with illegal set.
REQ-015 MEMADR SHALL drive alu_srcA=10, alu_srcB=01, imm_src I for loads and S for stores, then go to MEMREAD for loads or MEMWRITE for stores.
REQ-016 MEMREAD and MEMWRITE SHALL drive mem_req=1, adr_src=1, result_src=00; mem_write=1 only in MEMWRITE; on mem_ready=1 go to MEMWB or FETCH respectively.
REQ-017 MEMWB SHALL drive result_src=01, reg_write=1, then go to FETCH.
REQ-018 EXECR/EXECI SHALL select alu_srcB 00/01, derive alu_control from funct3/funct7b5 (sub and sra only when funct7b5=1; funct7b5 ignored for EXECI except srai), then go to ALUWB.
REQ-019 ALUWB SHALL drive result_src=00, reg_write=1, then go to FETCH.
REQ-020 BRANCH SHALL drive alu_srcA=10, alu_srcB=00, alu_control=sub, result_src=00; pc_write=1 when taken (beq zero, bne !zero, blt lt, bge !lt, bltu ltu, bgeu !ltu), else 0; next state FETCH.
REQ-021 JAL SHALL drive alu_srcA=01, alu_srcB=10, result_src=00, pc_write=1, then go to ALUWB.
REQ-022 LUI SHALL drive imm_src=100, result_src=10, reg_write=1 with alu_srcA=10 forced to add against zero by the datapath, then go to FETCH.
REQ-023 MULDIV SHALL pulse md_start=1 in its first cycle only, hold until md_done=1, then go to ALUWB; with EN_MULDIV=0, funct7b0=1 on op 0110011 SHALL go to TRAP with illegal set.
REQ-024 A wait counter SHALL clear on entry to FETCH/MEMREAD/MEMWRITE/MULDIV and increment each cycle the awaited ready/done is low; reaching WAIT_MAX SHALL go to TRAP with timeout_err set.
REQ-025 mem_ready arriving in the same cycle the counter reaches WAIT_MAX SHALL complete the access; no timeout.
REQ-026 TRAP SHALL hold all strobes at 0 and remain until reset; illegal and timeout_err are sticky.
REQ-027 instret SHALL increment by 1 on every transition into FETCH from a non-reset state, wrapping modulo 2^CNT_W.
REQ-028 Unlisted outputs in any state SHALL be 0.

Reset
REQ-029 reset_n=0 SHALL immediately force state=FETCH, wait counter=0, instret=0, illegal=0, timeout_err=0, and deassert all strobes, including mid-access and in TRAP.
REQ-030 The first FETCH after reset release SHALL assert mem_req on the first rising edge.

Verification
REQ-031 add x3,x1,x2 with mem_ready always 1 -> FETCH,DECODE,EXECR,ALUWB; reg_write one cycle; instret 0->1.
REQ-032 lw with mem_ready low 3 cycles in MEMREAD -> stays in state 3 for 4 cycles, then MEMWB, reg_write=1, result_src=01.
REQ-033 beq with zero=1 vs zero=0 -> pc_write=1 vs 0 in BRANCH; both return to FETCH in 3 cycles.
REQ-034 mem_ready held low in FETCH with WAIT_MAX=16 -> state=15, timeout_err=1 after 16 cycles; ir_write never asserted.
REQ-035 op=0000000 -> TRAP, illegal=1; reset_n pulse -> state=0, illegal=0, instret=0.
REQ-036 instret preloaded to all-ones (CNT_W=4, 15 instructions) -> next retirement wraps to 0.
